// File: rtl/snake_logic_sequencer_if.sv
// Controller and PRNG facing signals of the snake logic sequencer.
// The master drives ticks and random positions; the slave returns status and the LED image.
interface snake_logic_sequencer_if #(
   parameter int BOARD_BITS = 6
);
   logic                  logic_tick;
   logic                  no_update;
   logic [1:0]            direction_state;
   logic                  rand_valid;
   logic [BOARD_BITS-1:0] rand_pos;
   logic                  rand_req;
   logic                  logic_done;
   logic                  game_end;
   logic [63:0]           led_flat;

   modport master (
      output logic_tick, no_update, direction_state, rand_valid, rand_pos,
      input  rand_req, logic_done, game_end, led_flat
   );

   modport slave (
      input  logic_tick, no_update, direction_state, rand_valid, rand_pos,
      output rand_req, logic_done, game_end, led_flat
   );
endinterface

// File: rtl/snake_logic_sequencer.sv
// Snake game datapath sequencer: once per controller tick it moves, grows or blinks
// the snake, runs the food handshake with the PRNG and registers the 8x8 LED image.
//
// state  | meaning
// IDLE   | wait for logic_tick
// BLINK  | toggle head LED (paused or game over)
// MOVE   | compute new head from direction, flag eat
// CHECK  | body collision test
// COMMIT | write new head, advance tail or grow
// FOOD   | request PRNG until a free cell is offered
// DONE   | one-cycle logic_done pulse
module snake_logic_sequencer #(
   parameter int                    BOARD_BITS = 6,
   parameter logic [BOARD_BITS-1:0] INIT_TAIL  = 6'd26,
   parameter logic [BOARD_BITS-1:0] INIT_HEAD  = 6'd27,
   parameter logic [BOARD_BITS-1:0] INIT_FOOD  = 6'd30
) (
   input logic                  clka,
   input logic                  restart_n,
   snake_logic_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_BLINK, S_MOVE, S_CHECK, S_COMMIT, S_FOOD, S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [BOARD_BITS-1:0] r_ring [64];
   logic [5:0]            r_head_ptr;
   logic [5:0]            r_tail_ptr;
   logic [6:0]            r_length;
   logic [63:0]           r_occ;
   logic [BOARD_BITS-1:0] r_food;
   logic                  r_blink;
   logic                  r_game_end;
   logic [BOARD_BITS-1:0] r_new_head;
   logic                  r_eat;
   logic [63:0]           r_led;

   logic [BOARD_BITS-1:0] w_head_pos;
   logic [BOARD_BITS-1:0] w_tail_pos;
   logic [2:0]            w_row;
   logic [2:0]            w_col;
   logic [BOARD_BITS-1:0] w_move_head;
   logic                  w_collide;
   logic                  w_food_ok;
   logic [63:0]           w_new_bit;
   logic [63:0]           w_tail_bit;
   logic [63:0]           w_led_next;

   assign w_head_pos = r_ring[r_head_ptr];
   assign w_tail_pos = r_ring[r_tail_ptr];
   assign w_row      = w_head_pos[5:3];
   assign w_col      = w_head_pos[2:0];
   assign w_new_bit  = 64'd1 << r_new_head;
   assign w_tail_bit = 64'd1 << w_tail_pos;
   assign w_food_ok  = bus.rand_valid && !r_occ[bus.rand_pos];

   // The tail cell is free this tick unless the snake is growing.
   assign w_collide  = r_occ[r_new_head] && !((r_new_head == w_tail_pos) && !r_eat);

   assign w_led_next = (r_occ | (64'd1 << r_food)) ^ ({63'd0, r_blink} << w_head_pos);

   always_comb begin
      w_move_head = w_head_pos;
      case (bus.direction_state)
         2'd0: w_move_head = {w_row + 3'd1, w_col};
         2'd1: w_move_head = {w_row - 3'd1, w_col};
         2'd2: w_move_head = {w_row, w_col - 3'd1};
         2'd3: w_move_head = {w_row, w_col + 3'd1};
      endcase
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (bus.logic_tick)
                      w_next_state = (r_game_end || bus.no_update) ? S_BLINK : S_MOVE;
         S_BLINK:  w_next_state = S_DONE;
         S_MOVE:   w_next_state = S_CHECK;
         S_CHECK:  w_next_state = w_collide ? S_DONE : S_COMMIT;
         S_COMMIT: w_next_state = (!r_eat || r_length == 7'd63) ? S_DONE : S_FOOD;
         S_FOOD:   if (w_food_ok) w_next_state = S_DONE;
         S_DONE:   w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) r_state <= S_IDLE;
      else            r_state <= w_next_state;
   end

   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         for (int i = 0; i < 64; i++) r_ring[i] <= (i == 1) ? INIT_HEAD : INIT_TAIL;
         r_head_ptr <= 6'd1;
         r_tail_ptr <= 6'd0;
         r_length   <= 7'd2;
         r_occ      <= (64'd1 << INIT_TAIL) | (64'd1 << INIT_HEAD);
         r_food     <= INIT_FOOD;
         r_blink    <= 1'b0;
         r_game_end <= 1'b0;
         r_new_head <= '0;
         r_eat      <= 1'b0;
         r_led      <= (64'd1 << INIT_TAIL) | (64'd1 << INIT_HEAD) | (64'd1 << INIT_FOOD);
      end else begin
         r_led <= w_led_next;
         case (r_state)
            S_BLINK: r_blink <= ~r_blink;
            S_MOVE: begin
               r_new_head <= w_move_head;
               r_eat      <= (w_move_head == r_food);
            end
            S_CHECK: if (w_collide) r_game_end <= 1'b1;
            S_COMMIT: begin
               r_blink                    <= 1'b0;
               r_head_ptr                 <= r_head_ptr + 6'd1;
               r_ring[r_head_ptr + 6'd1]  <= r_new_head;
               if (r_eat) begin
                  r_occ    <= r_occ | w_new_bit;
                  r_length <= r_length + 7'd1;
                  if (r_length == 7'd63) r_game_end <= 1'b1;
               end else begin
                  // Set after clear so a head landing on the old tail stays occupied.
                  r_occ      <= (r_occ & ~w_tail_bit) | w_new_bit;
                  r_tail_ptr <= r_tail_ptr + 6'd1;
               end
            end
            S_FOOD: if (w_food_ok) r_food <= bus.rand_pos;
            default: ;
         endcase
      end
   end

   assign bus.rand_req   = (r_state == S_FOOD);
   assign bus.logic_done = (r_state == S_DONE);
   assign bus.game_end   = r_game_end;
   assign bus.led_flat   = r_led;

endmodule

// File: tb/tb_snake_logic_sequencer.sv
// Self-checking bench for snake_logic_sequencer: a behavioural game model pushes the
// expected latency, LED image and status per tick; results are popped on logic_done.
module tb_snake_logic_sequencer;

   logic clka;
   logic restart_n;

   snake_logic_sequencer_if bus ();

   snake_logic_sequencer dut (
      .clka      (clka),
      .restart_n (restart_n),
      .bus       (bus.slave)
   );

   initial clka = 1'b0;
   always #5 clka = ~clka;

   typedef struct {
      int          lat;
      logic [63:0] led;
      logic        ge;
      int          reqc;
   } exp_t;

   exp_t        sb[$];
   int          rq[$];
   int          m_body[$];
   logic [63:0] m_occ;
   int          m_food;
   logic        m_blink;
   logic        m_ge;
   int          checks;
   int          errors;

   task automatic model_reset();
      m_body.delete();
      m_body.push_back(26);
      m_body.push_back(27);
      m_occ   = (64'd1 << 26) | (64'd1 << 27);
      m_food  = 30;
      m_blink = 1'b0;
      m_ge    = 1'b0;
   endtask

   task automatic model_tick(input logic [1:0] dir, input logic nu, output exp_t e);
      int row, col, nh, tl, k;
      logic eat, coll;
      e.reqc = 0;
      if (m_ge || nu) begin
         m_blink = ~m_blink;
         e.lat   = 2;
      end else begin
         row = m_body[$] / 8;
         col = m_body[$] % 8;
         case (dir)
            2'd0: row = (row + 1) % 8;
            2'd1: row = (row + 7) % 8;
            2'd2: col = (col + 7) % 8;
            2'd3: col = (col + 1) % 8;
         endcase
         nh   = row * 8 + col;
         eat  = (nh == m_food);
         tl   = m_body[0];
         coll = m_occ[nh] && !((nh == tl) && !eat);
         if (coll) begin
            m_ge  = 1'b1;
            e.lat = 3;
         end else begin
            m_blink = 1'b0;
            m_body.push_back(nh);
            m_occ[nh] = 1'b1;
            if (!eat) begin
               if (nh != tl) m_occ[tl] = 1'b0;
               void'(m_body.pop_front());
               e.lat = 4;
            end else if (m_body.size() == 64) begin
               m_ge  = 1'b1;
               e.lat = 4;
            end else begin
               k = 0;
               while (k < rq.size() && m_occ[rq[k]]) k++;
               m_food = rq[k];
               e.lat  = 5 + k;
               e.reqc = k + 1;
            end
         end
      end
      e.led = m_occ | (64'd1 << m_food);
      if (m_blink) e.led ^= (64'd1 << m_body[$]);
      e.ge = m_ge;
   endtask

   task automatic apply_reset();
      bus.logic_tick      = 1'b0;
      bus.no_update       = 1'b0;
      bus.direction_state = 2'd0;
      bus.rand_valid      = 1'b0;
      bus.rand_pos        = '0;
      restart_n           = 1'b0;
      repeat (2) @(negedge clka);
      restart_n = 1'b1;
      model_reset();
      rq.delete();
      sb.delete();
      @(negedge clka);
   endtask

   task automatic do_tick(input logic [1:0] dir, input logic nu);
      exp_t e;
      int   cyc;
      int   reqc;
      logic seen;
      model_tick(dir, nu, e);
      sb.push_back(e);
      @(negedge clka);
      bus.direction_state = dir;
      bus.no_update       = nu;
      bus.logic_tick      = 1'b1;
      @(posedge clka);
      #1 bus.logic_tick = 1'b0;
      cyc  = 0;
      reqc = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clka);
         cyc++;
         if (bus.logic_done) seen = 1'b1;
         else if (bus.rand_req) begin
            reqc++;
            if (rq.size() > 0) begin
               bus.rand_valid = 1'b1;
               bus.rand_pos   = 6'(rq.pop_front());
            end else bus.rand_valid = 1'b0;
         end else bus.rand_valid = 1'b0;
      end
      bus.rand_valid = 1'b0;
      bus.no_update  = 1'b0;
      e = sb.pop_front();
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL tick_timeout: no logic_done within %0d cycles, expected cycle %0d", cyc, e.lat);
         return;
      end
      if (cyc !== e.lat) begin
         errors++;
         $display("FAIL tick_latency: got cycle %0d expected %0d", cyc, e.lat);
      end
      checks++;
      if (reqc !== e.reqc) begin
         errors++;
         $display("FAIL rand_req_cycles: got %0d expected %0d", reqc, e.reqc);
      end
      @(negedge clka);
      checks++;
      if (bus.led_flat !== e.led) begin
         errors++;
         $display("FAIL led_flat: got %h expected %h", bus.led_flat, e.led);
      end
      checks++;
      if (bus.game_end !== e.ge) begin
         errors++;
         $display("FAIL game_end: got %b expected %b", bus.game_end, e.ge);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (bus.led_flat !== 64'h0000_0000_4C00_0000) begin
         errors++;
         $display("FAIL reset_led: got %h expected %h", bus.led_flat, 64'h4C00_0000);
      end
      checks++;
      if ({bus.game_end, bus.rand_req, bus.logic_done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_status: got %b expected 000", {bus.game_end, bus.rand_req, bus.logic_done});
      end
   endtask

   task automatic test_move();
      apply_reset();
      do_tick(2'd3, 1'b0);
      checks++;
      if (bus.led_flat !== 64'h0000_0000_5800_0000) begin
         errors++;
         $display("FAIL move_led: got %h expected %h", bus.led_flat, 64'h5800_0000);
      end
   endtask

   task automatic test_food();
      apply_reset();
      do_tick(2'd3, 1'b0);
      do_tick(2'd3, 1'b0);
      rq = '{28, 0};
      do_tick(2'd3, 1'b0);
      checks++;
      if (bus.led_flat !== 64'h0000_0000_7000_0001) begin
         errors++;
         $display("FAIL food_led: got %h expected %h", bus.led_flat, 64'h7000_0001);
      end
      rq.delete();
   endtask

   task automatic test_wrap();
      do_tick(2'd3, 1'b0);
      do_tick(2'd3, 1'b0);
      checks++;
      if (bus.led_flat[24] !== 1'b1) begin
         errors++;
         $display("FAIL wrap_col: led bit24 got %b expected 1", bus.led_flat[24]);
      end
      do_tick(2'd3, 1'b0);
      for (int i = 0; i < 5; i++) do_tick(2'd0, 1'b0);
      checks++;
      if (bus.led_flat[1] !== 1'b1 || bus.game_end !== 1'b0) begin
         errors++;
         $display("FAIL wrap_row: led bit1 got %b game_end got %b expected 1 and 0",
                  bus.led_flat[1], bus.game_end);
      end
   endtask

   task automatic test_collision();
      apply_reset();
      do_tick(2'd3, 1'b0);
      do_tick(2'd3, 1'b0);
      rq = '{31};
      do_tick(2'd3, 1'b0);
      rq = '{24};
      do_tick(2'd3, 1'b0);
      rq = '{0};
      do_tick(2'd3, 1'b0);
      do_tick(2'd0, 1'b0);
      do_tick(2'd2, 1'b0);
      do_tick(2'd1, 1'b0);
      checks++;
      if (bus.game_end !== 1'b1) begin
         errors++;
         $display("FAIL collision_end: got %b expected 1", bus.game_end);
      end
      do_tick(2'd3, 1'b0);
      checks++;
      if (bus.led_flat[39] !== 1'b0) begin
         errors++;
         $display("FAIL blink_off: head bit got %b expected 0", bus.led_flat[39]);
      end
      do_tick(2'd3, 1'b0);
      checks++;
      if (bus.led_flat[39] !== 1'b1) begin
         errors++;
         $display("FAIL blink_on: head bit got %b expected 1", bus.led_flat[39]);
      end
   endtask

   task automatic test_tail_chase();
      logic [1:0] dirs[6];
      dirs = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd1};
      apply_reset();
      do_tick(2'd3, 1'b0);
      do_tick(2'd3, 1'b0);
      rq = '{38};
      do_tick(2'd3, 1'b0);
      rq = '{0};
      do_tick(2'd0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         do_tick(dirs[i], 1'b0);
         checks++;
         if ($countones(bus.led_flat & ~64'd1) !== 4 || bus.game_end !== 1'b0) begin
            errors++;
            $display("FAIL tail_chase_pop: step %0d popcount got %0d game_end %b expected 4 and 0",
                     i, $countones(bus.led_flat & ~64'd1), bus.game_end);
         end
      end
   endtask

   task automatic test_reset_in_food();
      int cyc;
      apply_reset();
      do_tick(2'd3, 1'b0);
      do_tick(2'd3, 1'b0);
      @(negedge clka);
      bus.direction_state = 2'd3;
      bus.logic_tick      = 1'b1;
      @(posedge clka);
      #1 bus.logic_tick = 1'b0;
      cyc = 0;
      while (!bus.rand_req && cyc < 20) begin
         @(negedge clka);
         cyc++;
      end
      checks++;
      if (bus.rand_req !== 1'b1) begin
         errors++;
         $display("FAIL food_reached: rand_req got %b expected 1", bus.rand_req);
      end
      restart_n = 1'b0;
      #1;
      checks++;
      if (bus.rand_req !== 1'b0) begin
         errors++;
         $display("FAIL async_req_drop: got %b expected 0", bus.rand_req);
      end
      @(posedge clka);
      #1;
      checks++;
      if (bus.led_flat !== 64'h0000_0000_4C00_0000) begin
         errors++;
         $display("FAIL abort_led: got %h expected %h", bus.led_flat, 64'h4C00_0000);
      end
      @(negedge clka);
      restart_n = 1'b1;
      model_reset();
      rq.delete();
      sb.delete();
      do_tick(2'd3, 1'b0);
      checks++;
      if (bus.led_flat !== 64'h0000_0000_5800_0000) begin
         errors++;
         $display("FAIL abort_no_commit: got %h expected %h", bus.led_flat, 64'h5800_0000);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      restart_n = 1'b0;
      test_reset();
      test_move();
      test_food();
      test_wrap();
      test_collision();
      test_tail_chase();
      test_reset_in_food();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/snake_logic_sequencer.md
Name: snake_logic_sequencer

Overview:
- Sequences the snake logic datapath once per game tick from the controller.
- Holds the snake body as a 64-entry ring buffer of board positions and keeps a 64-bit occupancy map.
- Computes the new head, detects body collision, and grows the snake or advances the tail.
- Runs the food handshake with the PRNG, returns done/end status to the controller, and drives the 8x8 LED image the controller multiplexes.

Parameters:
- BOARD_BITS, 6, position width; position index = row*8 + col; row 0 / col 0 is the bottom-left LED.
- INIT_TAIL, 26, reset tail position (row 3, col 2).
- INIT_HEAD, 27, reset head position (row 3, col 3).
- INIT_FOOD, 30, reset food position (row 3, col 6).

Ports:
- clka  in  1  system clock; all state updates on rising edge.
- restart_n  in  1  asynchronous active-low reset.
- logic_tick  in  1  start one update (controller to_logic[LOGIC_TICK]).
- no_update  in  1  with logic_tick: blink the head LED instead of moving (controller to_logic[NO_UPDATE]).
- direction_state  in  2  movement direction: 0=UP (row+1), 1=DOWN (row-1), 2=LEFT (col-1), 3=RIGHT (col+1).
- rand_valid  in  1  PRNG has a value on rand_pos.
- rand_pos  in  6  candidate food position.
- rand_req  out  1  food position request to the PRNG.
- logic_done  out  1  one-cycle pulse when an update is finished (controller from_logic[LOGIC_DONE]).
- game_end  out  1  sticky collision/board-full flag (controller from_logic[GAME_END]).
- led_flat  out  64  LED image; bit r*8+c is row r, column c.

Behaviour:
- Reset (restart_n low, asynchronous):
  - FSM goes to IDLE.
  - Ring buffer holds INIT_TAIL at slot 0 and INIT_HEAD at slot 1; tail_ptr=0, head_ptr=1, length=2.
  - Occupancy has bits 26 and 27 set; food=30; blink=0.
  - rand_req=0, logic_done=0, game_end=0, led_flat=0x0000_0000_4C00_0000.
  - Reset asserted mid-sequence aborts the sequence; no partial commit survives.
- led_flat = occupancy | (1<<food), with the head bit XORed by blink. Registered; updates on the clock after the state change.
- Ring pointers are 6-bit and wrap mod 64. length is 7-bit, range 2..64.
- FSM states:
  - IDLE: logic_tick=1 and game_end=1 (or no_update=1) -> BLINK. logic_tick=1 otherwise -> MOVE. logic_tick is ignored in every state except IDLE.
  - BLINK: toggle blink -> DONE.
  - MOVE: compute new_head from head position and direction_state, sampled here. Row and column each wrap mod 8 (row 7 UP -> row 0; col 0 LEFT -> col 7). eat = (new_head == food). Next -> CHECK.
  - CHECK: collision if occupancy[new_head]=1, except when new_head equals the tail position and eat=0 (tail vacates this tick).
    - Collision: set game_end, no commit -> DONE.
    - Otherwise -> COMMIT.
  - COMMIT: head_ptr+1; write new_head to that slot; set occupancy[new_head].
    - eat=0: clear occupancy[tail] (skipped when new_head==tail), tail_ptr+1 -> DONE.
    - eat=1: length+1; if length reaches 64, set game_end -> DONE; else -> FOOD.
  - FOOD: rand_req=1, held until rand_valid.
    - On rand_valid, sample rand_pos. If occupancy[rand_pos]=1, keep rand_req high and wait for the next rand_valid.
    - Otherwise set food=rand_pos, drop rand_req the next cycle -> DONE.
    - No timeout.
  - DONE: logic_done=1 for exactly one cycle -> IDLE.
- Latency, counting from the clock that samples logic_tick:
  - Non-eating move: logic_done high in cycle 4.
  - Collision: cycle 3.
  - Blink: cycle 2.
  - Eating: cycle 5 + PRNG wait cycles.
- game_end clears only on reset. Once set, every tick is a blink and the body never changes.
- blink is cleared whenever a real move commits.

Test Plan:
- Reset, then tick with dir=RIGHT: logic_done in cycle 4; led_flat bits 27,28,30 set, bit 26 clear; game_end=0.
- From reset, 3 ticks RIGHT: head reaches 30 (food); rand_req rises. Return rand_valid with rand_pos=28 (occupied), then 0: rand_req stays high after the first value; food=0; length=3; led_flat=0x0000_0000_7000_0001.
- Wrap: head at 31 moving RIGHT -> new head 24. Head at row 7 moving UP -> row 0, same column. No game_end in either case.
- Body collision: build length-5 snake, steer UP, LEFT, DOWN into own body -> game_end=1 in cycle 3, led_flat unchanged. Next two ticks toggle only the head bit, and logic_done arrives in cycle 2.
- Tail-chase: length-4 square loop whose new head equals the vacating tail -> no collision, and the occupancy popcount stays 4.
- Assert restart_n in the FOOD state with rand_req=1: rand_req drops immediately (asynchronously), and led_flat returns to 0x0000_0000_4C00_0000 on the next clock.
